// File: rtl/local_reduction_injector.sv
`default_nettype none
// local_reduction_injector: coalesces reduction contributions and formats 256-bit switch packets.
// Define LOCAL_REDUCTION_COALESCE_EN to enable the HOLD/merge path; otherwise every request is sent alone.
module local_reduction_injector #(
    parameter int DataWidth     = 256,
    parameter int PayloadLen    = 128,
    parameter int IndexPos      = 128,
    parameter int IndexWidth    = 16,
    parameter int WeightPos     = 144,
    parameter int WeightWidth   = 8,
    parameter int PriorityPos   = 152,
    parameter int PriorityWidth = 8,
    parameter int ExitPos       = 160,
    parameter int ExitWidth     = 4,
    parameter int MergeCntPos   = 164,
    parameter int MaxMerge      = 8,
    parameter int FlushTimeout  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_reduce,
    input  logic [IndexWidth-1:0]    req_index,
    input  logic [WeightWidth-1:0]   req_weight,
    input  logic [PayloadLen-1:0]    req_payload,
    input  logic [ExitWidth-1:0]     req_dst,
    input  logic [PriorityWidth-1:0] req_priority,
    input  logic                     out_avail,
    output logic [DataWidth-1:0]     out,
    output logic                     out_pipeline_stall
);

`ifdef LOCAL_REDUCTION_COALESCE_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_HOLD = 2'd1, S_SEND = 2'd2} state_t;
    localparam int IdleWidth = (FlushTimeout > 1) ? $clog2(FlushTimeout) : 1;
    logic [IdleWidth-1:0] idle_q, idle_d;
    logic                 match;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SEND = 2'd2} state_t;
`endif

    state_t                   state_q, state_d;
    logic                     reduce_q, reduce_d;
    logic [IndexWidth-1:0]    index_q, index_d;
    logic [WeightWidth-1:0]   weight_q, weight_d;
    logic [PayloadLen-1:0]    payload_q, payload_d;
    logic [ExitWidth-1:0]     dst_q, dst_d;
    logic [PriorityWidth-1:0] prio_q, prio_d;
    logic [2:0]               mcnt_q, mcnt_d;
    logic [DataWidth-1:0]     out_q, out_d;
    logic [DataWidth-1:0]     pkt_d;
    logic                     ready;

    always_comb begin
        state_d   = state_q;
        reduce_d  = reduce_q;
        index_d   = index_q;
        weight_d  = weight_q;
        payload_d = payload_q;
        dst_d     = dst_q;
        prio_d    = prio_q;
        mcnt_d    = mcnt_q;
        ready     = 1'b0;
`ifdef LOCAL_REDUCTION_COALESCE_EN
        idle_d = idle_q;
        match  = req_reduce && (req_index == index_q) && (req_dst == dst_q)
                 && (mcnt_q < 3'(MaxMerge - 1));
`endif
        case (state_q)
            S_IDLE: begin
                ready = 1'b1;
                if (req_valid) begin
                    reduce_d  = req_reduce;
                    index_d   = req_index;
                    weight_d  = req_weight;
                    payload_d = req_payload;
                    dst_d     = req_dst;
                    prio_d    = req_priority;
                    mcnt_d    = 3'd0;
`ifdef LOCAL_REDUCTION_COALESCE_EN
                    idle_d  = '0;
                    state_d = (req_reduce && (MaxMerge > 1)) ? S_HOLD : S_SEND;
`else
                    state_d = S_SEND;
`endif
                end
            end
`ifdef LOCAL_REDUCTION_COALESCE_EN
            S_HOLD: begin
                if (req_valid) begin
                    // A non-matching request stays pending and is picked up from IDLE.
                    if (match) begin
                        ready     = 1'b1;
                        payload_d = payload_q + req_payload;
                        weight_d  = weight_q + req_weight;
                        prio_d    = (req_priority > prio_q) ? req_priority : prio_q;
                        mcnt_d    = mcnt_q + 3'd1;
                        idle_d    = '0;
                        if (mcnt_d == 3'(MaxMerge - 1)) begin
                            state_d = S_SEND;
                        end
                    end else begin
                        state_d = S_SEND;
                    end
                end else if (idle_q == IdleWidth'(FlushTimeout - 1)) begin
                    state_d = S_SEND;
                end else begin
                    idle_d = idle_q + IdleWidth'(1);
                end
            end
`endif
            S_SEND: begin
                if (out_avail) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pkt_d                                   = '0;
        pkt_d[DataWidth-1]                      = 1'b1;
        pkt_d[DataWidth-2]                      = reduce_d;
        pkt_d[MergeCntPos +: 3]                 = mcnt_d;
        pkt_d[ExitPos +: ExitWidth]             = dst_d;
        pkt_d[PriorityPos +: PriorityWidth]     = prio_d;
        pkt_d[WeightPos +: WeightWidth]         = weight_d;
        pkt_d[IndexPos +: IndexWidth]           = index_d;
        pkt_d[0 +: PayloadLen]                  = payload_d;
        out_d = (state_d == S_SEND) ? pkt_d : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            reduce_q  <= 1'b0;
            index_q   <= '0;
            weight_q  <= '0;
            payload_q <= '0;
            dst_q     <= '0;
            prio_q    <= '0;
            mcnt_q    <= 3'd0;
            out_q     <= '0;
`ifdef LOCAL_REDUCTION_COALESCE_EN
            idle_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            reduce_q  <= reduce_d;
            index_q   <= index_d;
            weight_q  <= weight_d;
            payload_q <= payload_d;
            dst_q     <= dst_d;
            prio_q    <= prio_d;
            mcnt_q    <= mcnt_d;
            out_q     <= out_d;
`ifdef LOCAL_REDUCTION_COALESCE_EN
            idle_q    <= idle_d;
`endif
        end
    end

    // Ready is masked while reset is held so nothing is accepted into a state being cleared.
    assign req_ready          = ready & rst;
    assign out                = out_q;
    assign out_pipeline_stall = ~((state_q == S_SEND) && out_avail);

endmodule
`default_nettype wire

// File: tb/tb_local_reduction_injector.sv
`default_nettype none
// Bench for local_reduction_injector: vector table, hand-written corner sequences and a
// randomized run checked against a transaction-level grouping model.
module tb_local_reduction_injector;
    localparam int FT = 8;
    localparam int MM = 8;
`ifdef LOCAL_REDUCTION_COALESCE_EN
    localparam bit COAL = 1'b1;
`else
    localparam bit COAL = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic         req_reduce = 1'b0;
    logic [15:0]  req_index = '0;
    logic [7:0]   req_weight = '0;
    logic [127:0] req_payload = '0;
    logic [3:0]   req_dst = '0;
    logic [7:0]   req_priority = '0;
    logic         out_avail = 1'b1;
    logic [255:0] out;
    logic         out_pipeline_stall;

    always #5 clk = ~clk;

    local_reduction_injector #(.MaxMerge(MM), .FlushTimeout(FT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_reduce(req_reduce), .req_index(req_index), .req_weight(req_weight),
        .req_payload(req_payload), .req_dst(req_dst), .req_priority(req_priority),
        .out_avail(out_avail), .out(out), .out_pipeline_stall(out_pipeline_stall)
    );

    typedef struct {
        logic r; logic [15:0] ix; logic [7:0] w; logic [127:0] pl;
        logic [3:0] d; logic [7:0] p; logic [127:0] exp_hi;
    } vec_t;
    typedef struct {
        logic r; logic [15:0] ix; logic [7:0] w; logic [127:0] pl;
        logic [3:0] d; logic [7:0] p; int cyc;
    } req_t;

    int total = 0;
    int bad = 0;
    req_t scriptq[$];
    req_t accq[$];
    logic [255:0] obsq[$];
    logic [255:0] expq[$];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check32(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    function automatic logic [255:0] pack(input logic r, input logic [2:0] m, input logic [3:0] d,
                                          input logic [7:0] p, input logic [7:0] w,
                                          input logic [15:0] ix, input logic [127:0] pl);
        return {1'b1, r, 87'd0, m, d, p, w, ix, pl};
    endfunction

    function automatic req_t mk(input logic r, input logic [15:0] ix, input logic [7:0] w,
                                input logic [127:0] pl, input logic [3:0] d, input logic [7:0] p);
        req_t t;
        t.r = r; t.ix = ix; t.w = w; t.pl = pl; t.d = d; t.p = p; t.cyc = 0;
        return t;
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive(input logic r, input logic [15:0] ix, input logic [7:0] w,
                         input logic [127:0] pl, input logic [3:0] d, input logic [7:0] p);
        req_valid = 1'b1; req_reduce = r; req_index = ix; req_weight = w;
        req_payload = pl; req_dst = d; req_priority = p;
    endtask

    // Called in the cycle after the last accept; lat counts cycles from that accept.
    task automatic wait_pkt(output logic [255:0] pkt, output int lat);
        lat = 1;
        while (!out[255] && lat < 40) begin
            step();
            lat++;
        end
        pkt = out;
        if (!out[255]) begin
            total++;
            bad++;
            $display("FAIL pkt_timeout: no packet after %0d cycles, want one", lat);
        end
    endtask

    // Presents scriptq back-to-back, each held until accepted, and logs every transfer.
    task automatic run_script(input int ncyc);
        int k;
        bit acc;
        k = 0;
        acc = 1'b0;
        obsq.delete();
        for (int c = 0; c < ncyc; c++) begin
            step();
            if (acc) begin
                req_valid = 1'b0;
                k++;
            end
            if (!req_valid && k < scriptq.size())
                drive(scriptq[k].r, scriptq[k].ix, scriptq[k].w, scriptq[k].pl, scriptq[k].d, scriptq[k].p);
            out_avail = 1'b1;
            settle();
            acc = req_valid && req_ready;
            if (out[255] && out_avail) obsq.push_back(out);
        end
        req_valid = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t         vt[5];
        logic [255:0] pkt;
        int           lat;
        bit           acc_last;
        int           idle_left;
        bit           prev_stalled;
        logic [255:0] prev_out;
        req_t         h;
        req_t         g;
        int           i, j, cnt, last;

        vt[0] = '{1'b0, 16'h0000, 8'h00, 128'd5, 4'h3, 8'h00,
                  128'h8000_0000_0000_0000_0000_0003_0000_0000};
        vt[1] = '{1'b0, 16'hFFFF, 8'h80, {4{32'hFFFF_FFFF}}, 4'hF, 8'hFF,
                  128'h8000_0000_0000_0000_0000_000F_FF80_FFFF};
        vt[2] = '{1'b1, 16'h1234, 8'h02, 128'd1, 4'h7, 8'h01,
                  128'hC000_0000_0000_0000_0000_0007_0102_1234};
        vt[3] = '{1'b0, 16'hA5A5, 8'h5A, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_FEDC_BA98, 4'h9, 8'h3C,
                  128'h8000_0000_0000_0000_0000_0009_3C5A_A5A5};
        vt[4] = '{1'b1, 16'h0001, 8'hFF, 128'd0, 4'hA, 8'h80,
                  128'hC000_0000_0000_0000_0000_000A_80FF_0001};

        // Reset behaviour
        #2 rst = 1'b0;
        drive(1'b0, 16'h1, 8'h1, 128'd1, 4'h1, 8'h1);
        step();
        check32("rst_ready", req_ready, 0);
        check32("rst_stall", out_pipeline_stall, 1);
        check("rst_out", out, '0);
        rst = 1'b1;
        req_valid = 1'b0;
        settle();
        check32("rst_ready_after", req_ready, 1);

        // Single-transaction vector table
        for (int v = 0; v < 5; v++) begin
            step();
            drive(vt[v].r, vt[v].ix, vt[v].w, vt[v].pl, vt[v].d, vt[v].p);
            out_avail = 1'b1;
            settle();
            check32("tbl_ready", req_ready, 1);
            step();
            req_valid = 1'b0;
            wait_pkt(pkt, lat);
            check32("tbl_lat", lat, (vt[v].r && COAL) ? FT + 1 : 1);
            check("tbl_pkt", pkt, {vt[v].exp_hi, vt[v].pl});
            check32("tbl_stall", out_pipeline_stall, 0);
            step();
            check("tbl_clear", out, '0);
            check32("tbl_ready2", req_ready, 1);
        end

        // Back-pressure: packet held stable for 10 cycles
        step();
        drive(1'b0, 16'h0, 8'h0, 128'd77, 4'h1, 8'h0);
        out_avail = 1'b0;
        settle();
        step();
        req_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            check("stall_hold", out, pack(1'b0, 3'd0, 4'h1, 8'h0, 8'h0, 16'h0, 128'd77));
            check32("stall_flag", out_pipeline_stall, 1);
            step();
        end
        out_avail = 1'b1;
        settle();
        check32("stall_release", out_pipeline_stall, 0);
        step();
        check("stall_done", out, '0);

        // Reset in the middle of SEND
        step();
        drive(1'b0, 16'h2, 8'h3, 128'd99, 4'h4, 8'h5);
        out_avail = 1'b0;
        settle();
        step();
        req_valid = 1'b0;
        check32("rsend_valid", out[255], 1);
        #2 rst = 1'b0;
        out_avail = 1'b1;
        #1;
        check("rsend_out", out, '0);
        check32("rsend_stall", out_pipeline_stall, 1);
        step();
        step();
        rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            check32("rsend_noemit", out[255], 0);
        end
        check32("rsend_ready", req_ready, 1);

        // Two same-index contributions
        scriptq.delete();
        scriptq.push_back(mk(1'b1, 16'h5, 8'd1, 128'd100, 4'h1, 8'd4));
        scriptq.push_back(mk(1'b1, 16'h5, 8'd2, 128'd200, 4'h1, 8'd9));
        run_script(40);
`ifdef LOCAL_REDUCTION_COALESCE_EN
        check32("same_cnt", obsq.size(), 1);
        if (obsq.size() > 0)
            check("same_pkt0", obsq[0], pack(1'b1, 3'd1, 4'h1, 8'd9, 8'd3, 16'h5, 128'd300));
`else
        check32("same_cnt", obsq.size(), 2);
        if (obsq.size() > 1) begin
            check("same_pkt0", obsq[0], pack(1'b1, 3'd0, 4'h1, 8'd4, 8'd1, 16'h5, 128'd100));
            check("same_pkt1", obsq[1], pack(1'b1, 3'd0, 4'h1, 8'd9, 8'd2, 16'h5, 128'd200));
        end
`endif

`ifdef LOCAL_REDUCTION_COALESCE_EN
        // Three-way merge then timeout
        scriptq.delete();
        scriptq.push_back(mk(1'b1, 16'h0010, 8'd1, 128'd10, 4'h0, 8'd0));
        scriptq.push_back(mk(1'b1, 16'h0010, 8'd2, 128'd20, 4'h0, 8'd0));
        scriptq.push_back(mk(1'b1, 16'h0010, 8'd3, 128'd30, 4'h0, 8'd0));
        run_script(40);
        check32("m3_cnt", obsq.size(), 1);
        if (obsq.size() > 0)
            check("m3_pkt", obsq[0], pack(1'b1, 3'd2, 4'h0, 8'd0, 8'd6, 16'h0010, 128'd60));

        // Full merge of MaxMerge contributions, then a ninth opens a new packet
        for (int k = 0; k < 8; k++) begin
            step();
            drive(1'b1, 16'h7, 8'(k + 1), 128'(k + 1), 4'h2, 8'(k));
            out_avail = 1'b1;
            settle();
            check32("m8_ready", req_ready, 1);
        end
        step();
        drive(1'b1, 16'h7, 8'h40, 128'd9, 4'h2, 8'h1);
        settle();
        check("m8_pkt", out, pack(1'b1, 3'd7, 4'h2, 8'd7, 8'd36, 16'h7, 128'd36));
        check32("m8_ninth_wait", req_ready, 0);
        step();
        check32("m8_ninth_acc", req_ready, 1);
        step();
        req_valid = 1'b0;
        wait_pkt(pkt, lat);
        check("m8_ninth_pkt", pkt, pack(1'b1, 3'd0, 4'h2, 8'd1, 8'h40, 16'h7, 128'd9));
        check32("m8_ninth_lat", lat, FT + 1);
        step();

        // Index change while holding
        step();
        drive(1'b1, 16'd5, 8'd1, 128'd11, 4'd0, 8'd0);
        settle();
        check32("ix_acc5", req_ready, 1);
        step();
        drive(1'b1, 16'd6, 8'd2, 128'd22, 4'd0, 8'd0);
        settle();
        check32("ix_block6", req_ready, 0);
        step();
        check("ix_pkt5", out, pack(1'b1, 3'd0, 4'd0, 8'd0, 8'd1, 16'd5, 128'd11));
        check32("ix_send_ready", req_ready, 0);
        step();
        check32("ix_acc6", req_ready, 1);
        step();
        req_valid = 1'b0;
        wait_pkt(pkt, lat);
        check("ix_pkt6", pkt, pack(1'b1, 3'd0, 4'd0, 8'd0, 8'd2, 16'd6, 128'd22));
        step();
`endif

        // Randomized traffic against the grouping model
        req_valid = 1'b0;
        acc_last = 1'b0;
        idle_left = 0;
        prev_stalled = 1'b0;
        prev_out = '0;
        accq.delete();
        obsq.delete();
        for (int c = 0; c < 700; c++) begin
            step();
            if (prev_stalled) check("rand_hold", out, prev_out);
            if (acc_last) req_valid = 1'b0;
            if (c >= 600) begin
                out_avail = 1'b1;
            end else begin
                if (!req_valid) begin
                    if (idle_left > 0) begin
                        idle_left--;
                    end else begin
                        drive(($urandom_range(0, 3) != 0), 16'($urandom_range(0, 1)), 8'($urandom),
                              {$urandom, $urandom, $urandom, $urandom}, 4'($urandom_range(0, 1)),
                              8'($urandom));
                        idle_left = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 12) : 0;
                    end
                end
                out_avail = ($urandom_range(0, 3) != 0);
            end
            settle();
            acc_last = req_valid && req_ready;
            if (acc_last) begin
                g = mk(req_reduce, req_index, req_weight, req_payload, req_dst, req_priority);
                g.cyc = c;
                accq.push_back(g);
            end
            if (out[255] && out_avail) obsq.push_back(out);
            check32("rand_stall", out_pipeline_stall, !(out[255] && out_avail));
            prev_stalled = out[255] && !out_avail;
            prev_out = out;
        end
        req_valid = 1'b0;

        expq.delete();
        i = 0;
        while (i < accq.size()) begin
            h = accq[i];
            cnt = 1;
            last = accq[i].cyc;
            j = i + 1;
            while (COAL && h.r && j < accq.size() && cnt < MM && accq[j].r &&
                   accq[j].ix == h.ix && accq[j].d == h.d && (accq[j].cyc - last) <= FT) begin
                h.w = h.w + accq[j].w;
                h.pl = h.pl + accq[j].pl;
                if (accq[j].p > h.p) h.p = accq[j].p;
                last = accq[j].cyc;
                cnt++;
                j++;
            end
            expq.push_back(pack(h.r, 3'(cnt - 1), h.d, h.p, h.w, h.ix, h.pl));
            i = j;
        end
        check32("rand_count", obsq.size(), expq.size());
        for (int k = 0; k < obsq.size() && k < expq.size(); k++)
            check("rand_pkt", obsq[k], expq[k]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
